// File: rtl/csr_trap_seq_pkg.sv
// Shared machine-mode CSR constants and trap sequencer state encoding.
// The cause-word helper packs the interrupt flag into the top bit of mcause.
package csr_trap_seq_pkg;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_MEPC   = 3'd1,
        ST_W_MCAUSE = 3'd2,
        ST_W_MTVAL  = 3'd3,
        ST_T_REDIR  = 3'd4,
        ST_R_REDIR  = 3'd5
    } state_t;

    function automatic logic [31:0] cause_word(input logic [4:0] src);
        return {src[4], 27'b0, src[3:0]};
    endfunction

endpackage

// File: rtl/csr_trap_seq_if.sv
// Pipeline/CSR-file side signals of the trap sequencer. trap and mret are
// single-cycle pulses with no back-pressure; stall is the only flow control.
interface csr_trap_seq_if;

    logic        trap;
    logic [4:0]  trap_src;
    logic        misalign;
    logic [31:0] dmem_addr;
    logic [31:0] pc;
    logic        mret;
    logic [31:0] mtvec_rdata;
    logic [31:0] mepc_rdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap_overrun;

    modport master (
        output trap, trap_src, misalign, dmem_addr, pc, mret, mtvec_rdata, mepc_rdata,
        input  csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc, trap_overrun
    );

    modport slave (
        input  trap, trap_src, misalign, dmem_addr, pc, mret, mtvec_rdata, mepc_rdata,
        output csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc, trap_overrun
    );

endinterface

// File: rtl/csr_trap_seq.sv
// Trap/mret sequencer: serialises mepc, mcause and optional mtval writes over the
// single CSR write port, then issues one redirect to the handler or return pc.
module csr_trap_seq
    import csr_trap_seq_pkg::*;
#(
    parameter bit MTVAL_EN = 1'b1,
    parameter bit VECTORED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    csr_trap_seq_if.slave     bus,
    output state_t            o_dbg_state
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [4:0]  r_src;
    logic        r_misalign;
    logic [31:0] r_addr;
    logic        r_overrun;

    logic        w_we;
    logic [11:0] w_waddr;
    logic [31:0] w_wdata;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_base;
    logic [31:0] w_vec_off;
    logic        w_vectored;
    logic        w_req;
    logic        w_unused;

    assign w_req      = bus.trap | bus.mret;
    assign w_base     = {bus.mtvec_rdata[31:2], 2'b00};
    assign w_vec_off  = {26'b0, r_src[3:0], 2'b00};
    assign w_vectored = VECTORED && (bus.mtvec_rdata[1:0] == 2'b01) && r_src[4];
    assign w_unused   = &{1'b0, bus.mepc_rdata[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_src      <= '0;
            r_misalign <= 1'b0;
            r_addr     <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && bus.trap) begin
                r_pc       <= bus.pc;
                r_src      <= bus.trap_src;
                r_misalign <= bus.misalign;
                r_addr     <= bus.dmem_addr;
            end
            // Requests while busy are dropped; only the sticky flag records them.
            if (w_req && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_we          = 1'b0;
        w_waddr       = '0;
        w_wdata       = '0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.trap) begin
                    w_next = ST_W_MEPC;
                end else if (bus.mret) begin
                    w_next = ST_R_REDIR;
                end
            end
            ST_W_MEPC: begin
                w_we    = 1'b1;
                w_waddr = CSR_MEPC;
                w_wdata = r_pc;
                w_next  = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                w_we    = 1'b1;
                w_waddr = CSR_MCAUSE;
                w_wdata = cause_word(r_src);
                w_next  = (MTVAL_EN && r_misalign) ? ST_W_MTVAL : ST_T_REDIR;
            end
            ST_W_MTVAL: begin
                w_we    = 1'b1;
                w_waddr = CSR_MTVAL;
                w_wdata = r_addr;
                w_next  = ST_T_REDIR;
            end
            ST_T_REDIR: begin
                w_redirect    = 1'b1;
                w_redirect_pc = w_base + (w_vectored ? w_vec_off : 32'd0);
                w_next        = ST_IDLE;
            end
            ST_R_REDIR: begin
                w_redirect    = 1'b1;
                w_redirect_pc = {bus.mepc_rdata[31:2], 2'b00};
                w_next        = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        // Reset cycle must not leak a write or redirect from the aborted sequence.
        if (rst) begin
            w_we          = 1'b0;
            w_waddr       = '0;
            w_wdata       = '0;
            w_redirect    = 1'b0;
            w_redirect_pc = '0;
        end
    end

    assign bus.csr_we       = w_we;
    assign bus.csr_waddr    = w_waddr;
    assign bus.csr_wdata    = w_wdata;
    assign bus.redirect     = w_redirect;
    assign bus.redirect_pc  = w_redirect_pc;
    assign bus.stall        = w_req | (!rst && r_state != ST_IDLE);
    assign bus.trap_overrun = r_overrun;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Bench for csr_trap_seq: two instances (all features on / MTVAL_EN=0,VECTORED=0)
// share one stimulus stream and are compared against a queue-of-cycles model.
module tb_csr_trap_seq;
    import csr_trap_seq_pkg::*;

    typedef struct packed {
        logic [1:0]  kind;   // 0 idle, 1 csr write, 2 trap redirect, 3 mret redirect
        logic [11:0] addr;
        logic [31:0] data;
        logic [4:0]  src;
    } rec_t;
    localparam int RW = $bits(rec_t);

    logic   clk;
    logic   rst;
    state_t dbg_a;
    state_t dbg_b;
    int     n_vec;
    int     n_err;

    logic [RW-1:0] exp_qa[$];
    logic [RW-1:0] exp_qb[$];
    logic          ovr_a;
    logic          ovr_b;

    csr_trap_seq_if bus_a();
    csr_trap_seq_if bus_b();

    assign bus_b.trap        = bus_a.trap;
    assign bus_b.trap_src    = bus_a.trap_src;
    assign bus_b.misalign    = bus_a.misalign;
    assign bus_b.dmem_addr   = bus_a.dmem_addr;
    assign bus_b.pc          = bus_a.pc;
    assign bus_b.mret        = bus_a.mret;
    assign bus_b.mtvec_rdata = bus_a.mtvec_rdata;
    assign bus_b.mepc_rdata  = bus_a.mepc_rdata;

    csr_trap_seq #(.MTVAL_EN(1'b1), .VECTORED(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave), .o_dbg_state(dbg_a)
    );
    csr_trap_seq #(.MTVAL_EN(1'b0), .VECTORED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave), .o_dbg_state(dbg_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic [1:0] kind, input logic [11:0] addr,
                                         input logic [31:0] data, input logic [4:0] src);
        rec_t r;
        r.kind = kind;
        r.addr = addr;
        r.data = data;
        r.src  = src;
        return r;
    endfunction

    task automatic check_dut(input string nm, input rec_t r, input logic raw_busy,
                             input logic ovr, input logic vect, input logic we,
                             input logic [11:0] wa, input logic [31:0] wd, input logic rd,
                             input logic [31:0] rp, input logic st, input logic ov,
                             input state_t dbg);
        logic        e_we;
        logic        e_rd;
        logic [31:0] e_rp;
        logic [31:0] base;
        e_we = (r.kind == 2'd1);
        e_rd = (r.kind >= 2'd2);
        base = bus_a.mtvec_rdata & 32'hFFFF_FFFC;
        e_rp = 32'd0;
        if (r.kind == 2'd2) begin
            e_rp = base;
            if (vect && bus_a.mtvec_rdata[1:0] == 2'b01 && r.src[4])
                e_rp = base + 32'(r.src[3:0]) * 32'd4;
        end else if (r.kind == 2'd3) begin
            e_rp = bus_a.mepc_rdata & 32'hFFFF_FFFC;
        end
        chk({nm, "_we"}, 32'(we), 32'(e_we));
        chk({nm, "_waddr"}, 32'(wa), e_we ? 32'(r.addr) : 32'd0);
        chk({nm, "_wdata"}, wd, e_we ? r.data : 32'd0);
        chk({nm, "_redirect"}, 32'(rd), 32'(e_rd));
        chk({nm, "_redirect_pc"}, rp, e_rp);
        chk({nm, "_stall"}, 32'(st),
            32'(bus_a.trap | bus_a.mret | (raw_busy & ~rst)));
        chk({nm, "_overrun"}, 32'(ov), 32'(ovr));
        if (!rst) chk({nm, "_busy"}, 32'(dbg != ST_IDLE), 32'(raw_busy));
    endtask

    task automatic model_step();
        rec_t        ra;
        rec_t        rb;
        logic        busy_a;
        logic        busy_b;
        logic [31:0] cause;
        busy_a = (exp_qa.size() != 0);
        busy_b = (exp_qb.size() != 0);
        ra = '0;
        rb = '0;
        if (busy_a) ra = exp_qa.pop_front();
        if (busy_b) rb = exp_qb.pop_front();
        if (rst) begin
            ra = '0;
            rb = '0;
        end
        check_dut("a", ra, busy_a, ovr_a, 1'b1, bus_a.csr_we, bus_a.csr_waddr, bus_a.csr_wdata,
                  bus_a.redirect, bus_a.redirect_pc, bus_a.stall, bus_a.trap_overrun, dbg_a);
        check_dut("b", rb, busy_b, ovr_b, 1'b0, bus_b.csr_we, bus_b.csr_waddr, bus_b.csr_wdata,
                  bus_b.redirect, bus_b.redirect_pc, bus_b.stall, bus_b.trap_overrun, dbg_b);
        // advance model to the next clock edge
        cause = (bus_a.trap_src[4] ? 32'h8000_0000 : 32'd0) + 32'(bus_a.trap_src[3:0]);
        if (rst) begin
            exp_qa.delete();
            exp_qb.delete();
            ovr_a = 1'b0;
            ovr_b = 1'b0;
        end else begin
            if (busy_a && (bus_a.trap || bus_a.mret)) ovr_a = 1'b1;
            if (busy_b && (bus_a.trap || bus_a.mret)) ovr_b = 1'b1;
            if (!busy_a && bus_a.trap) begin
                exp_qa.push_back(mk(2'd1, CSR_MEPC, bus_a.pc, 5'd0));
                exp_qa.push_back(mk(2'd1, CSR_MCAUSE, cause, 5'd0));
                if (bus_a.misalign) exp_qa.push_back(mk(2'd1, CSR_MTVAL, bus_a.dmem_addr, 5'd0));
                exp_qa.push_back(mk(2'd2, 12'd0, 32'd0, bus_a.trap_src));
            end else if (!busy_a && bus_a.mret) begin
                exp_qa.push_back(mk(2'd3, 12'd0, 32'd0, 5'd0));
            end
            if (!busy_b && bus_a.trap) begin
                exp_qb.push_back(mk(2'd1, CSR_MEPC, bus_a.pc, 5'd0));
                exp_qb.push_back(mk(2'd1, CSR_MCAUSE, cause, 5'd0));
                exp_qb.push_back(mk(2'd2, 12'd0, 32'd0, bus_a.trap_src));
            end else if (!busy_b && bus_a.mret) begin
                exp_qb.push_back(mk(2'd3, 12'd0, 32'd0, 5'd0));
            end
        end
    endtask

    // driver: apply one cycle of inputs at negedge, check 1ns later
    task automatic drive(input logic t, input logic [4:0] s, input logic mis,
                         input logic [31:0] addr, input logic [31:0] p, input logic m,
                         input logic [31:0] tv, input logic [31:0] ep, input logic r);
        @(negedge clk);
        rst               = r;
        bus_a.trap        = t;
        bus_a.trap_src    = s;
        bus_a.misalign    = mis;
        bus_a.dmem_addr   = addr;
        bus_a.pc          = p;
        bus_a.mret        = m;
        bus_a.mtvec_rdata = tv;
        bus_a.mepc_rdata  = ep;
        #1;
        model_step();
    endtask

    task automatic idle(input logic [31:0] tv, input logic [31:0] ep);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, tv, ep, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ovr_a = 1'b0;
        ovr_b = 1'b0;
        rst = 1'b1;
        bus_a.trap = 1'b0;
        bus_a.trap_src = '0;
        bus_a.misalign = 1'b0;
        bus_a.dmem_addr = '0;
        bus_a.pc = '0;
        bus_a.mret = 1'b0;
        bus_a.mtvec_rdata = '0;
        bus_a.mepc_rdata = '0;

        // T1 reset held two cycles
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
        idle(32'h2000, 32'h0);
        chk("t1_state", 32'(dbg_a), 32'(ST_IDLE));
        chk("t1_stall", 32'(bus_a.stall), 32'd0);

        // T2 synchronous trap
        drive(1'b1, 5'h02, 1'b0, 32'd0, 32'h100, 1'b0, 32'h2000, 32'h0, 1'b0);
        idle(32'h2000, 32'h0);
        chk("t2_mepc", bus_a.csr_wdata, 32'h100);
        idle(32'h2000, 32'h0);
        chk("t2_mcause", bus_a.csr_wdata, 32'h2);
        idle(32'h2000, 32'h0);
        chk("t2_redirect", 32'(bus_a.redirect), 32'd1);
        chk("t2_rpc", bus_a.redirect_pc, 32'h2000);
        idle(32'h2000, 32'h0);
        chk("t2_stall_drop", 32'(bus_a.stall), 32'd0);

        // T3 misaligned load
        drive(1'b1, 5'h04, 1'b1, 32'h1003, 32'h200, 1'b0, 32'h2000, 32'h0, 1'b0);
        idle(32'h2000, 32'h0);
        idle(32'h2000, 32'h0);
        idle(32'h2000, 32'h0);
        chk("t3_mtval_addr", 32'(bus_a.csr_waddr), 32'(CSR_MTVAL));
        chk("t3_mtval", bus_a.csr_wdata, 32'h1003);
        chk("t3_b_redirect", 32'(bus_b.redirect), 32'd1);
        idle(32'h2000, 32'h0);
        chk("t3_a_redirect", 32'(bus_a.redirect), 32'd1);

        // T4 vectored interrupt
        drive(1'b1, 5'h17, 1'b0, 32'd0, 32'h300, 1'b0, 32'h3001, 32'h0, 1'b0);
        idle(32'h3001, 32'h0);
        idle(32'h3001, 32'h0);
        chk("t4_mcause", bus_a.csr_wdata, 32'h8000_0007);
        idle(32'h3001, 32'h0);
        chk("t4_rpc_vec", bus_a.redirect_pc, 32'h301C);
        chk("t4_rpc_direct", bus_b.redirect_pc, 32'h3000);

        // T5 mret, then trap+mret together
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h3001, 32'h104, 1'b0);
        idle(32'h3001, 32'h104);
        chk("t5_mret_rpc", bus_a.redirect_pc, 32'h104);
        chk("t5_mret_we", 32'(bus_a.csr_we), 32'd0);
        drive(1'b1, 5'h02, 1'b0, 32'd0, 32'h400, 1'b1, 32'h2000, 32'h104, 1'b0);
        idle(32'h2000, 32'h104);
        chk("t5_both_mepc", 32'(bus_a.csr_waddr), 32'(CSR_MEPC));
        idle(32'h2000, 32'h104);
        idle(32'h2000, 32'h104);

        // T6 overrun during W_MCAUSE, then reset in W_MEPC
        drive(1'b1, 5'h03, 1'b0, 32'd0, 32'h500, 1'b0, 32'h2000, 32'h0, 1'b0);
        idle(32'h2000, 32'h0);
        drive(1'b1, 5'h05, 1'b0, 32'd0, 32'h600, 1'b0, 32'h2000, 32'h0, 1'b0);
        idle(32'h2000, 32'h0);
        chk("t6_overrun", 32'(bus_a.trap_overrun), 32'd1);
        chk("t6_redirect_kept", bus_a.redirect_pc, 32'h2000);
        idle(32'h2000, 32'h0);
        drive(1'b1, 5'h02, 1'b0, 32'd0, 32'h700, 1'b0, 32'h2000, 32'h0, 1'b0);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h2000, 32'h0, 1'b1);
        idle(32'h2000, 32'h0);
        chk("t6_rst_we", 32'(bus_a.csr_we), 32'd0);
        chk("t6_rst_ovr", 32'(bus_a.trap_overrun), 32'd0);
        idle(32'h2000, 32'h0);
        chk("t6_rst_redir", 32'(bus_a.redirect), 32'd0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tv;
            logic [31:0] rnd;
            tv = $urandom();
            rnd = $urandom();
            if (rnd[0]) tv[1:0] = 2'b01;
            drive($urandom_range(0, 5) == 0, 5'($urandom_range(0, 31)), rnd[1],
                  $urandom(), $urandom(), $urandom_range(0, 7) == 0, tv, $urandom(),
                  $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
